// File: rtl/cpu_muldiv_sequencer.sv
// cpu_muldiv_sequencer: issues RV32M operations to shared unsigned multiplier /
// divider units, applies sign handling around them and returns a tagged result.
// Optional build macro CPU_MULDIV_CACHE_EN adds a one-entry result cache that
// lets a repeated operand pair complete on the one-cycle bypass path.
module cpu_muldiv_sequencer #(
    parameter int unsigned MUL_LATENCY = 3,
    parameter int unsigned DIV_LATENCY = 34
) (
    input  logic        i_clock,
    input  logic        i_reset_n,
    input  logic        i_valid,
    output logic        o_ready,
    input  logic [2:0]  i_op,
    input  logic [31:0] i_rs1,
    input  logic [31:0] i_rs2,
    input  logic [7:0]  i_tag,
    input  logic        i_flush,
    output logic [31:0] o_mul_op1,
    output logic [31:0] o_mul_op2,
    input  logic [63:0] i_mul_result,
    output logic [31:0] o_div_numerator,
    output logic [31:0] o_div_denominator,
    input  logic [31:0] i_div_result,
    input  logic [31:0] i_div_remainder,
    output logic        o_valid,
    output logic [31:0] o_result,
    output logic [7:0]  o_tag,
    output logic        o_busy
);

    localparam int unsigned XLEN  = 32;
    localparam int unsigned PLEN  = 64;
    localparam int unsigned TAG_W = 8;
    localparam int unsigned CNT_W = 6;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_MUL_WAIT = 2'd1,
        S_DIV_WAIT = 2'd2,
        S_DONE     = 2'd3
    } state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [1:0]        sub_op_q, sub_op_d;
    logic              neg_a_q, neg_a_d;
    logic              neg_b_q, neg_b_d;
    logic [TAG_W-1:0]  tag_q, tag_d;
    logic [XLEN-1:0]   mul_op1_q, mul_op1_d;
    logic [XLEN-1:0]   mul_op2_q, mul_op2_d;
    logic [XLEN-1:0]   div_num_q, div_num_d;
    logic [XLEN-1:0]   div_den_q, div_den_d;
    logic [XLEN-1:0]   result_q, result_d;
    logic [TAG_W-1:0]  res_tag_q, res_tag_d;
    logic              valid_q, valid_d;
    logic              ready_q, ready_d;
    logic              busy_q, busy_d;

    // request decode
    logic              accept;
    logic              req_sgn_a, req_sgn_b;
    logic              req_neg_a, req_neg_b;
    logic [XLEN-1:0]   req_mag1, req_mag2;
    logic              req_div_zero, req_ovf, req_special;
    logic [XLEN-1:0]   special_res;

    // unit result fixup
    logic              res_neg;
    logic [PLEN-1:0]   prod_fix;
    logic [XLEN-1:0]   quot_fix, rem_fix;
    logic [XLEN-1:0]   mul_res, div_res;

    // cache lookup (tied off when the cache is not built)
    logic              cache_hit;
    logic [XLEN-1:0]   cache_res;

    assign o_ready           = ready_q;
    assign o_busy            = busy_q;
    assign o_valid           = valid_q;
    assign o_result          = result_q;
    assign o_tag             = res_tag_q;
    assign o_mul_op1         = mul_op1_q;
    assign o_mul_op2         = mul_op2_q;
    assign o_div_numerator   = div_num_q;
    assign o_div_denominator = div_den_q;

    // Decode the incoming request: signedness, magnitudes and divider special cases
    always_comb begin
        req_sgn_a = 1'b0;
        req_sgn_b = 1'b0;
        case (i_op)
            3'd1, 3'd4, 3'd6: begin
                req_sgn_a = 1'b1;
                req_sgn_b = 1'b1;
            end
            3'd2:    req_sgn_a = 1'b1;
            default: ;
        endcase
        accept       = (state_q == S_IDLE) && i_valid && !i_flush;
        req_neg_a    = req_sgn_a & i_rs1[XLEN-1];
        req_neg_b    = req_sgn_b & i_rs2[XLEN-1];
        req_mag1     = req_neg_a ? (~i_rs1 + XLEN'(1)) : i_rs1;
        req_mag2     = req_neg_b ? (~i_rs2 + XLEN'(1)) : i_rs2;
        req_div_zero = i_op[2] && (i_rs2 == '0);
        req_ovf      = i_op[2] && !i_op[0] && (i_rs1 == 32'h8000_0000) && (i_rs2 == 32'hFFFF_FFFF);
        req_special  = req_div_zero || req_ovf;
        special_res  = '0;
        if (req_div_zero) begin
            special_res = i_op[1] ? i_rs1 : 32'hFFFF_FFFF;
        end else if (req_ovf) begin
            special_res = i_op[1] ? 32'h0000_0000 : 32'h8000_0000;
        end
    end

    // Restore signs on the unsigned unit outputs for the operation in flight
    always_comb begin
        res_neg  = neg_a_q ^ neg_b_q;
        prod_fix = res_neg ? (~i_mul_result + PLEN'(1)) : i_mul_result;
        quot_fix = res_neg ? (~i_div_result + XLEN'(1)) : i_div_result;
        rem_fix  = neg_a_q ? (~i_div_remainder + XLEN'(1)) : i_div_remainder;
        mul_res  = (sub_op_q == 2'd0) ? prod_fix[XLEN-1:0] : prod_fix[PLEN-1:XLEN];
        div_res  = sub_op_q[1] ? rem_fix : quot_fix;
    end

`ifdef CPU_MULDIV_CACHE_EN
    logic              c_vld_q, c_vld_d;
    logic              c_div_q, c_div_d;
    logic [1:0]        c_sgn_q, c_sgn_d;
    logic [XLEN-1:0]   c_rs1_q, c_rs1_d;
    logic [XLEN-1:0]   c_rs2_q, c_rs2_d;
    logic [PLEN-1:0]   c_prod_q, c_prod_d;
    logic [XLEN-1:0]   c_quot_q, c_quot_d;
    logic [XLEN-1:0]   c_rem_q, c_rem_d;
    logic [1:0]        pend_sgn_q, pend_sgn_d;
    logic [XLEN-1:0]   pend_rs1_q, pend_rs1_d;
    logic [XLEN-1:0]   pend_rs2_q, pend_rs2_d;

    // Cache lookup, pending-request capture and entry fill/invalidate
    always_comb begin
        c_vld_d    = c_vld_q;
        c_div_d    = c_div_q;
        c_sgn_d    = c_sgn_q;
        c_rs1_d    = c_rs1_q;
        c_rs2_d    = c_rs2_q;
        c_prod_d   = c_prod_q;
        c_quot_d   = c_quot_q;
        c_rem_d    = c_rem_q;
        pend_sgn_d = pend_sgn_q;
        pend_rs1_d = pend_rs1_q;
        pend_rs2_d = pend_rs2_q;

        cache_hit = c_vld_q && (c_div_q == i_op[2]) && (c_sgn_q == {req_sgn_a, req_sgn_b})
                    && (c_rs1_q == i_rs1) && (c_rs2_q == i_rs2);
        if (c_div_q) begin
            cache_res = i_op[1] ? c_rem_q : c_quot_q;
        end else begin
            cache_res = (i_op[1:0] == 2'd0) ? c_prod_q[XLEN-1:0] : c_prod_q[PLEN-1:XLEN];
        end

        if (accept) begin
            pend_sgn_d = {req_sgn_a, req_sgn_b};
            pend_rs1_d = i_rs1;
            pend_rs2_d = i_rs2;
        end

        if (i_flush) begin
            c_vld_d = 1'b0;
        end else if (accept && req_special) begin
            c_vld_d = 1'b0;
        end else if ((state_q == S_MUL_WAIT) && (cnt_q == '0)) begin
            c_vld_d  = 1'b1;
            c_div_d  = 1'b0;
            c_sgn_d  = pend_sgn_q;
            c_rs1_d  = pend_rs1_q;
            c_rs2_d  = pend_rs2_q;
            c_prod_d = prod_fix;
        end else if ((state_q == S_DIV_WAIT) && (cnt_q == '0)) begin
            c_vld_d  = 1'b1;
            c_div_d  = 1'b1;
            c_sgn_d  = pend_sgn_q;
            c_rs1_d  = pend_rs1_q;
            c_rs2_d  = pend_rs2_q;
            c_quot_d = quot_fix;
            c_rem_d  = rem_fix;
        end
    end

    // Cache entry and pending-request registers
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            c_vld_q    <= 1'b0;
            c_div_q    <= 1'b0;
            c_sgn_q    <= '0;
            c_rs1_q    <= '0;
            c_rs2_q    <= '0;
            c_prod_q   <= '0;
            c_quot_q   <= '0;
            c_rem_q    <= '0;
            pend_sgn_q <= '0;
            pend_rs1_q <= '0;
            pend_rs2_q <= '0;
        end else begin
            c_vld_q    <= c_vld_d;
            c_div_q    <= c_div_d;
            c_sgn_q    <= c_sgn_d;
            c_rs1_q    <= c_rs1_d;
            c_rs2_q    <= c_rs2_d;
            c_prod_q   <= c_prod_d;
            c_quot_q   <= c_quot_d;
            c_rem_q    <= c_rem_d;
            pend_sgn_q <= pend_sgn_d;
            pend_rs1_q <= pend_rs1_d;
            pend_rs2_q <= pend_rs2_d;
        end
    end
`else
    assign cache_hit = 1'b0;
    assign cache_res = '0;
`endif

    // Sequencer next-state and registered outputs
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        sub_op_d  = sub_op_q;
        neg_a_d   = neg_a_q;
        neg_b_d   = neg_b_q;
        tag_d     = tag_q;
        mul_op1_d = mul_op1_q;
        mul_op2_d = mul_op2_q;
        div_num_d = div_num_q;
        div_den_d = div_den_q;
        result_d  = result_q;
        res_tag_d = res_tag_q;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    sub_op_d = i_op[1:0];
                    tag_d    = i_tag;
                    neg_a_d  = req_neg_a;
                    neg_b_d  = req_neg_b;
                    if (req_special) begin
                        result_d  = special_res;
                        res_tag_d = i_tag;
                        state_d   = S_DONE;
                    end else if (cache_hit) begin
                        result_d  = cache_res;
                        res_tag_d = i_tag;
                        state_d   = S_DONE;
                    end else if (i_op[2]) begin
                        div_num_d = req_mag1;
                        div_den_d = req_mag2;
                        cnt_d     = CNT_W'(DIV_LATENCY - 1);
                        state_d   = S_DIV_WAIT;
                    end else begin
                        mul_op1_d = req_mag1;
                        mul_op2_d = req_mag2;
                        cnt_d     = CNT_W'(MUL_LATENCY - 1);
                        state_d   = S_MUL_WAIT;
                    end
                end
            end
            S_MUL_WAIT: begin
                if (i_flush) begin
                    state_d = S_IDLE;
                end else if (cnt_q == '0) begin
                    result_d  = mul_res;
                    res_tag_d = tag_q;
                    state_d   = S_DONE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_DIV_WAIT: begin
                if (i_flush) begin
                    state_d = S_IDLE;
                end else if (cnt_q == '0) begin
                    result_d  = div_res;
                    res_tag_d = tag_q;
                    state_d   = S_DONE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        valid_d = (state_d == S_DONE);
        ready_d = (state_d == S_IDLE);
        busy_d  = (state_d != S_IDLE);
    end

    // State and output registers
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            sub_op_q  <= '0;
            neg_a_q   <= 1'b0;
            neg_b_q   <= 1'b0;
            tag_q     <= '0;
            mul_op1_q <= '0;
            mul_op2_q <= '0;
            div_num_q <= '0;
            div_den_q <= '0;
            result_q  <= '0;
            res_tag_q <= '0;
            valid_q   <= 1'b0;
            ready_q   <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            sub_op_q  <= sub_op_d;
            neg_a_q   <= neg_a_d;
            neg_b_q   <= neg_b_d;
            tag_q     <= tag_d;
            mul_op1_q <= mul_op1_d;
            mul_op2_q <= mul_op2_d;
            div_num_q <= div_num_d;
            div_den_q <= div_den_d;
            result_q  <= result_d;
            res_tag_q <= res_tag_d;
            valid_q   <= valid_d;
            ready_q   <= ready_d;
            busy_q    <= busy_d;
        end
    end

endmodule

// File: tb/tb_cpu_muldiv_sequencer.sv
// Directed bench for cpu_muldiv_sequencer with pipelined unsigned unit models.
module tb_cpu_muldiv_sequencer;

    localparam int unsigned MUL_LAT = 3;
    localparam int unsigned DIV_LAT = 34;
`ifdef CPU_MULDIV_CACHE_EN
    localparam bit CACHE = 1'b1;
`else
    localparam bit CACHE = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_valid = 1'b0;
    logic        o_ready;
    logic [2:0]  i_op = '0;
    logic [31:0] i_rs1 = '0;
    logic [31:0] i_rs2 = '0;
    logic [7:0]  i_tag = '0;
    logic        i_flush = 1'b0;
    logic [31:0] mul_op1, mul_op2;
    logic [63:0] mul_result;
    logic [31:0] div_num, div_den;
    logic [31:0] div_q, div_r;
    logic        o_valid;
    logic [31:0] o_result;
    logic [7:0]  o_tag;
    logic        o_busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cpu_muldiv_sequencer #(.MUL_LATENCY(MUL_LAT), .DIV_LATENCY(DIV_LAT)) dut (
        .i_clock(clk), .i_reset_n(rst_n), .i_valid(i_valid), .o_ready(o_ready),
        .i_op(i_op), .i_rs1(i_rs1), .i_rs2(i_rs2), .i_tag(i_tag), .i_flush(i_flush),
        .o_mul_op1(mul_op1), .o_mul_op2(mul_op2), .i_mul_result(mul_result),
        .o_div_numerator(div_num), .o_div_denominator(div_den),
        .i_div_result(div_q), .i_div_remainder(div_r),
        .o_valid(o_valid), .o_result(o_result), .o_tag(o_tag), .o_busy(o_busy)
    );

    // Unit models: result appears LATENCY cycles after the operands are applied
    logic [63:0] mul_pipe [MUL_LAT-1];
    logic [63:0] div_pipe [DIV_LAT-1];
    always @(posedge clk) begin
        mul_pipe[0] <= 64'(mul_op1) * 64'(mul_op2);
        for (int i = 1; i < int'(MUL_LAT) - 1; i++) mul_pipe[i] <= mul_pipe[i-1];
        if (div_den == 32'd0) div_pipe[0] <= {32'hFFFF_FFFF, div_num};
        else                  div_pipe[0] <= {div_num / div_den, div_num % div_den};
        for (int i = 1; i < int'(DIV_LAT) - 1; i++) div_pipe[i] <= div_pipe[i-1];
    end
    assign mul_result = mul_pipe[MUL_LAT-2];
    assign div_q      = div_pipe[DIV_LAT-2][63:32];
    assign div_r      = div_pipe[DIV_LAT-2][31:0];

    // Issue one request and check latency, result, tag, hold and handshake behaviour
    task automatic exec_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic [7:0] tag, input logic [31:0] exp_res,
                           input int exp_lat, input bit bypass, input string name);
        logic [127:0] pre_ops, held_ops;
        int lat;
        bit ok_hold, ok_hs;
        @(negedge clk);
        checks++;
        if (o_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s ready_before: got %b want 1", name, o_ready);
        end
        pre_ops = {mul_op1, mul_op2, div_num, div_den};
        i_valid = 1'b1; i_op = op; i_rs1 = a; i_rs2 = b; i_tag = tag;
        @(posedge clk); #1;
        i_valid = 1'b0;
        held_ops = {mul_op1, mul_op2, div_num, div_den};
        if (bypass) begin
            checks++;
            if (held_ops !== pre_ops) begin
                errors++;
                $display("FAIL %s ops_untouched: got %h want %h", name, held_ops, pre_ops);
            end
        end
        lat = 0; ok_hold = 1'b1; ok_hs = 1'b1;
        while (o_valid !== 1'b1 && lat < 100) begin
            if (o_ready !== 1'b0 || o_busy !== 1'b1) ok_hs = 1'b0;
            if ({mul_op1, mul_op2, div_num, div_den} !== held_ops) ok_hold = 1'b0;
            @(posedge clk); #1;
            lat++;
        end
        checks++;
        if (lat != exp_lat) begin
            errors++;
            $display("FAIL %s latency: got %0d want %0d", name, lat, exp_lat);
        end
        checks++;
        if (o_result !== exp_res) begin
            errors++;
            $display("FAIL %s result: got %h want %h", name, o_result, exp_res);
        end
        checks++;
        if (o_tag !== tag) begin
            errors++;
            $display("FAIL %s tag: got %h want %h", name, o_tag, tag);
        end
        checks++;
        if (o_busy !== 1'b1 || o_ready !== 1'b0) begin
            errors++;
            $display("FAIL %s done_flags: got busy=%b ready=%b want busy=1 ready=0", name, o_busy, o_ready);
        end
        if (!bypass) begin
            checks++;
            if (!(ok_hold && ok_hs)) begin
                errors++;
                $display("FAIL %s wait_hold: got hold=%b handshake=%b want 1 1", name, ok_hold, ok_hs);
            end
        end
        @(posedge clk); #1;
        checks++;
        if (o_valid !== 1'b0 || o_ready !== 1'b1 || o_busy !== 1'b0 || o_result !== exp_res) begin
            errors++;
            $display("FAIL %s after_done: got valid=%b ready=%b busy=%b res=%h want 0 1 0 %h",
                     name, o_valid, o_ready, o_busy, o_result, exp_res);
        end
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if (o_valid !== 1'b0 || o_busy !== 1'b0 || o_result !== 32'd0 || o_tag !== 8'd0) begin
            errors++;
            $display("FAIL reset_outputs: got valid=%b busy=%b res=%h tag=%h want 0 0 0 0",
                     o_valid, o_busy, o_result, o_tag);
        end
        checks++;
        if ({mul_op1, mul_op2, div_num, div_den} !== 128'd0) begin
            errors++;
            $display("FAIL reset_operands: got %h want 0", {mul_op1, mul_op2, div_num, div_den});
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (o_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready: got %b want 1", o_ready);
        end
    endtask

    task automatic test_mul();
        exec_op(3'd0, 32'd7, 32'd6, 8'h11, 32'd42, MUL_LAT, 1'b0, "mul_7x6");
        exec_op(3'd1, 32'hFFFF_FFFF, 32'd2, 8'h12, 32'hFFFF_FFFF, MUL_LAT, 1'b0, "mulh_m1x2");
        exec_op(3'd3, 32'hFFFF_FFFF, 32'd2, 8'h13, 32'h0000_0001, MUL_LAT, 1'b0, "mulhu_m1x2");
        exec_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 8'h14, 32'h8000_0000, MUL_LAT, 1'b0, "mulhsu_min");
    endtask

    task automatic test_div();
        exec_op(3'd4, 32'hFFFF_FFF9, 32'd2, 8'h21, 32'hFFFF_FFFD, DIV_LAT, 1'b0, "div_m7_2");
        exec_op(3'd6, 32'hFFFF_FFF9, 32'd2, 8'h22, 32'hFFFF_FFFF, CACHE ? 0 : DIV_LAT, CACHE, "rem_m7_2");
        exec_op(3'd5, 32'd100, 32'd7, 8'h23, 32'd14, DIV_LAT, 1'b0, "divu_100_7");
        exec_op(3'd7, 32'd100, 32'd7, 8'h24, 32'd2, CACHE ? 0 : DIV_LAT, CACHE, "remu_100_7");
    endtask

    task automatic test_special();
        exec_op(3'd4, 32'd9, 32'd0, 8'h31, 32'hFFFF_FFFF, 0, 1'b1, "div_by_zero");
        exec_op(3'd5, 32'd9, 32'd0, 8'h32, 32'hFFFF_FFFF, 0, 1'b1, "divu_by_zero");
        exec_op(3'd7, 32'd5, 32'd0, 8'h33, 32'd5, 0, 1'b1, "remu_by_zero");
        exec_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 8'h34, 32'h8000_0000, 0, 1'b1, "div_overflow");
        exec_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 8'h35, 32'h0000_0000, 0, 1'b1, "rem_overflow");
    endtask

    task automatic test_flush();
        logic [31:0] prev_res;
        logic [7:0]  prev_tag;
        int seen;
        // flush in IDLE blocks acceptance
        @(negedge clk);
        i_valid = 1'b1; i_op = 3'd0; i_rs1 = 32'd3; i_rs2 = 32'd3; i_tag = 8'h40; i_flush = 1'b1;
        @(posedge clk); #1;
        i_valid = 1'b0; i_flush = 1'b0;
        checks++;
        if (o_ready !== 1'b1 || o_busy !== 1'b0) begin
            errors++;
            $display("FAIL flush_idle_block: got ready=%b busy=%b want 1 0", o_ready, o_busy);
        end
        // flush five cycles into a divide
        prev_res = o_result;
        prev_tag = o_tag;
        @(negedge clk);
        i_valid = 1'b1; i_op = 3'd5; i_rs1 = 32'd100; i_rs2 = 32'd7; i_tag = 8'h41;
        @(posedge clk); #1;
        i_valid = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        i_flush = 1'b1;
        @(posedge clk); #1;
        i_flush = 1'b0;
        checks++;
        if (o_ready !== 1'b1 || o_busy !== 1'b0 || o_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_div_abort: got ready=%b busy=%b valid=%b want 1 0 0", o_ready, o_busy, o_valid);
        end
        seen = 0;
        repeat (DIV_LAT + 5) begin
            @(posedge clk); #1;
            if (o_valid === 1'b1) seen++;
        end
        checks++;
        if (seen != 0 || o_result !== prev_res || o_tag !== prev_tag) begin
            errors++;
            $display("FAIL flush_no_result: got valids=%0d res=%h tag=%h want 0 %h %h",
                     seen, o_result, o_tag, prev_res, prev_tag);
        end
    endtask

    task automatic test_reset_mid();
        int seen;
        @(negedge clk);
        i_valid = 1'b1; i_op = 3'd0; i_rs1 = 32'd9; i_rs2 = 32'd9; i_tag = 8'h51;
        @(posedge clk); #1;
        i_valid = 1'b0;
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (o_valid !== 1'b0 || o_busy !== 1'b0 || o_ready !== 1'b1 || o_result !== 32'd0 || o_tag !== 8'd0) begin
            errors++;
            $display("FAIL reset_mid_outputs: got valid=%b busy=%b ready=%b res=%h tag=%h want 0 0 1 0 0",
                     o_valid, o_busy, o_ready, o_result, o_tag);
        end
        checks++;
        if ({mul_op1, mul_op2, div_num, div_den} !== 128'd0) begin
            errors++;
            $display("FAIL reset_mid_operands: got %h want 0", {mul_op1, mul_op2, div_num, div_den});
        end
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (10) begin
            @(posedge clk); #1;
            if (o_valid === 1'b1) seen++;
        end
        checks++;
        if (seen != 0 || o_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_stale: got valids=%0d ready=%b want 0 1", seen, o_ready);
        end
    endtask

    task automatic test_cache();
        exec_op(3'd3, 32'h1234_5678, 32'h9ABC_DEF0, 8'h61, 32'h0B00_EA4E, MUL_LAT, 1'b0, "cache_mulhu");
        exec_op(3'd0, 32'h1234_5678, 32'h9ABC_DEF0, 8'h62, 32'h242D_2080,
                CACHE ? 0 : MUL_LAT, CACHE, "cache_mul");
        exec_op(3'd5, 32'h1234_5678, 32'h9ABC_DEF0, 8'h63, 32'h0000_0000, DIV_LAT, 1'b0, "cache_divu_miss");
    endtask

    initial begin
        test_reset();
        test_mul();
        test_div();
        test_special();
        test_flush();
        test_reset_mid();
        test_cache();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
